// File: rtl/avl_bus_n21_arbiter.sv
// rtl/avl_bus_n21_arbiter.sv - N-to-1 Avalon arbiter with registered grant and read-ID return FIFO
module avl_bus_n21_arbiter #(
    parameter int MASTER_NUM     = 4,
    parameter int ARB_METHOD     = 0,
    parameter int SEL_FIFO_DEPTH = 8,
    localparam int ID_W          = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1
) (
    input  logic                  clk,
    input  logic                  rest,
    input  logic [MASTER_NUM-1:0] m_read,
    input  logic [MASTER_NUM-1:0] m_write,
    output logic [MASTER_NUM-1:0] m_waitrequest,
    input  logic                  s_waitrequest,
    input  logic                  s_readdatavalid,
    output logic [MASTER_NUM-1:0] grant,
    output logic [ID_W-1:0]       grant_id,
    output logic                  grant_valid,
    output logic [MASTER_NUM-1:0] rdv_sel,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  err_rdv
);

    localparam int PTR_W = $clog2(SEL_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t                  state_q, state_d;
    logic [MASTER_NUM-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]         grant_id_q, grant_id_d;
    logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]         ptr_acc, ptr_eff, sel_id;
    logic                    sel_found;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [ID_W-1:0]         id_mem [SEL_FIFO_DEPTH];
    logic                    err_q;
    logic [MASTER_NUM-1:0]   req, eligible;
    logic                    live, accept, push, pop, room;

    assign live    = (state_q == S_GRANT);
    assign req     = m_read | m_write;
    assign accept  = live & req[grant_id_q] & ~s_waitrequest;
    assign push    = accept & m_read[grant_id_q];
    assign pop     = s_readdatavalid & (cnt_q != '0);
    assign cnt_d   = cnt_q + CNT_W'(push) - CNT_W'(pop);
    assign room    = (cnt_d < CNT_W'(SEL_FIFO_DEPTH));
    assign ptr_acc = ID_W'((int'(grant_id_q) + 1) % MASTER_NUM);
    assign ptr_eff = accept ? ptr_acc : rr_ptr_q;

    // A read-plus-write request is treated as a read, so it needs FIFO room.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            eligible[i] = m_read[i] ? room : m_write[i];
        end
    end

    always_comb begin
        int idx;
        sel_found = 1'b0;
        sel_id    = '0;
        idx       = 0;
        if (ARB_METHOD == 1) begin
            for (int i = MASTER_NUM - 1; i >= 0; i--) begin
                if (eligible[i]) begin
                    sel_found = 1'b1;
                    sel_id    = ID_W'(i);
                end
            end
        end else begin
            for (int k = 0; k < MASTER_NUM; k++) begin
                idx = (int'(ptr_eff) + k) % MASTER_NUM;
                if (!sel_found && eligible[idx]) begin
                    sel_found = 1'b1;
                    sel_id    = ID_W'(idx);
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    state_d    = S_GRANT;
                    grant_id_d = sel_id;
                end
            end
            S_GRANT: begin
                if (accept) begin
                    rr_ptr_d = ptr_acc;
                    if (sel_found) begin
                        grant_id_d = sel_id;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (!req[grant_id_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        grant_d = (state_d == S_GRANT) ? (MASTER_NUM'(1) << grant_id_d) : '0;
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (s_readdatavalid && (cnt_q == '0)) err_q <= 1'b1;
        end
    end

    // Payload storage needs no reset: occupancy is tracked by cnt_q alone.
    always_ff @(posedge clk) begin
        if (push) id_mem[wr_ptr_q] <= grant_id_q;
    end

    assign grant         = grant_q;
    assign grant_id      = grant_id_q;
    assign grant_valid   = live;
    assign m_waitrequest = ~({MASTER_NUM{live}} & grant_q) | {MASTER_NUM{s_waitrequest}};
    assign rdv_sel       = pop ? (MASTER_NUM'(1) << id_mem[rd_ptr_q]) : '0;
    assign fifo_full     = (cnt_q == CNT_W'(SEL_FIFO_DEPTH));
    assign fifo_empty    = (cnt_q == '0);
    assign err_rdv       = err_q;

endmodule

// File: tb/tb_avl_bus_n21_arbiter.sv
// tb/tb_avl_bus_n21_arbiter.sv - directed checks of round-robin/fixed-priority arbitration and read-ID FIFO
module tb_avl_bus_n21_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic       rr_rest, rr_swait, rr_rdv, rr_gv, rr_full, rr_empty, rr_err;
    logic [3:0] rr_read, rr_write, rr_wreq, rr_grant, rr_rsel;
    logic [1:0] rr_gid;

    logic       fp_rest, fp_swait, fp_rdv, fp_gv, fp_full, fp_empty, fp_err;
    logic [3:0] fp_read, fp_write, fp_wreq, fp_grant, fp_rsel;
    logic [1:0] fp_gid;

    avl_bus_n21_arbiter #(.MASTER_NUM(4), .ARB_METHOD(0), .SEL_FIFO_DEPTH(4)) u_rr (
        .clk(clk), .rest(rr_rest), .m_read(rr_read), .m_write(rr_write),
        .m_waitrequest(rr_wreq), .s_waitrequest(rr_swait), .s_readdatavalid(rr_rdv),
        .grant(rr_grant), .grant_id(rr_gid), .grant_valid(rr_gv), .rdv_sel(rr_rsel),
        .fifo_full(rr_full), .fifo_empty(rr_empty), .err_rdv(rr_err)
    );

    avl_bus_n21_arbiter #(.MASTER_NUM(4), .ARB_METHOD(1), .SEL_FIFO_DEPTH(8)) u_fp (
        .clk(clk), .rest(fp_rest), .m_read(fp_read), .m_write(fp_write),
        .m_waitrequest(fp_wreq), .s_waitrequest(fp_swait), .s_readdatavalid(fp_rdv),
        .grant(fp_grant), .grant_id(fp_gid), .grant_valid(fp_gv), .rdv_sel(fp_rsel),
        .fifo_full(fp_full), .fifo_empty(fp_empty), .err_rdv(fp_err)
    );

    task automatic test_reset();
        rr_rest = 1'b0; rr_read = '0; rr_write = '0; rr_swait = 1'b0; rr_rdv = 1'b0;
        fp_rest = 1'b0; fp_read = '0; fp_write = '0; fp_swait = 1'b0; fp_rdv = 1'b0;
        repeat (3) @(negedge clk);
        rr_rest = 1'b1; fp_rest = 1'b1;
        #1;
        if (rr_grant !== 4'b0000) begin $display("FAIL rst_grant got=%b exp=0000", rr_grant); n_fail++; end n_tests++;
        if (rr_gid !== 2'd0) begin $display("FAIL rst_gid got=%0d exp=0", rr_gid); n_fail++; end n_tests++;
        if (rr_gv !== 1'b0) begin $display("FAIL rst_gv got=%b exp=0", rr_gv); n_fail++; end n_tests++;
        if (rr_empty !== 1'b1) begin $display("FAIL rst_empty got=%b exp=1", rr_empty); n_fail++; end n_tests++;
        if (rr_full !== 1'b0) begin $display("FAIL rst_full got=%b exp=0", rr_full); n_fail++; end n_tests++;
        if (rr_err !== 1'b0) begin $display("FAIL rst_err got=%b exp=0", rr_err); n_fail++; end n_tests++;
        if (rr_wreq !== 4'b1111) begin $display("FAIL rst_wreq got=%b exp=1111", rr_wreq); n_fail++; end n_tests++;
        if (rr_rsel !== 4'b0000) begin $display("FAIL rst_rsel got=%b exp=0000", rr_rsel); n_fail++; end n_tests++;
        if (fp_gv !== 1'b0) begin $display("FAIL rst_fp_gv got=%b exp=0", fp_gv); n_fail++; end n_tests++;
        if (fp_empty !== 1'b1) begin $display("FAIL rst_fp_empty got=%b exp=1", fp_empty); n_fail++; end n_tests++;
    endtask

    task automatic test_rr_back_to_back();
        logic [1:0] exp_g [6];
        logic [3:0] exp_r [6];
        exp_g = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        exp_r = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010};
        @(negedge clk);
        rr_read = 4'b0111;
        #1;
        if (rr_gv !== 1'b0) begin $display("FAIL rr_latency got=%b exp=0", rr_gv); n_fail++; end n_tests++;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k >= 1) rr_rdv = 1'b1;
            #1;
            if (rr_gv !== 1'b1 || rr_gid !== exp_g[k]) begin
                $display("FAIL rr_grant_seq[%0d] got=%b/%0d exp=1/%0d", k, rr_gv, rr_gid, exp_g[k]); n_fail++;
            end
            n_tests++;
            if (k >= 1) begin
                if (rr_rsel !== exp_r[k]) begin $display("FAIL rr_rdv_sel[%0d] got=%b exp=%b", k, rr_rsel, exp_r[k]); n_fail++; end
                n_tests++;
            end
        end
        rr_read = '0;
        @(negedge clk);
        rr_rdv = 1'b0;
        #1;
        if (rr_empty !== 1'b1) begin $display("FAIL rr_drained got=%b exp=1", rr_empty); n_fail++; end n_tests++;
        if (rr_gv !== 1'b0) begin $display("FAIL rr_to_idle got=%b exp=0", rr_gv); n_fail++; end n_tests++;
    endtask

    task automatic test_reset_mid_traffic();
        @(negedge clk);
        rr_read = 4'b0111;
        repeat (4) @(negedge clk);
        #1;
        if (rr_empty !== 1'b0 || rr_gv !== 1'b1) begin
            $display("FAIL mid_pre got=empty%b/gv%b exp=empty0/gv1", rr_empty, rr_gv); n_fail++;
        end
        n_tests++;
        rr_rest = 1'b0;
        #1;
        if (rr_grant !== 4'b0000) begin $display("FAIL mid_grant got=%b exp=0000", rr_grant); n_fail++; end n_tests++;
        if (rr_gv !== 1'b0) begin $display("FAIL mid_gv got=%b exp=0", rr_gv); n_fail++; end n_tests++;
        if (rr_empty !== 1'b1) begin $display("FAIL mid_empty got=%b exp=1", rr_empty); n_fail++; end n_tests++;
        if (rr_wreq !== 4'b1111) begin $display("FAIL mid_wreq got=%b exp=1111", rr_wreq); n_fail++; end n_tests++;
        rr_read = '0;
        @(negedge clk);
        rr_rest = 1'b1;
        @(negedge clk);
        #1;
        if (rr_empty !== 1'b1 || rr_gv !== 1'b0) begin
            $display("FAIL mid_post got=empty%b/gv%b exp=empty1/gv0", rr_empty, rr_gv); n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_fifo_full();
        @(negedge clk);
        rr_read = 4'b0001;
        repeat (4) @(negedge clk);
        #1;
        if (rr_gid !== 2'd0 || rr_full !== 1'b0) begin $display("FAIL ff_fill got=%0d/%b exp=0/0", rr_gid, rr_full); n_fail++; end n_tests++;
        @(negedge clk);
        #1;
        if (rr_full !== 1'b1) begin $display("FAIL ff_full got=%b exp=1", rr_full); n_fail++; end n_tests++;
        if (rr_gv !== 1'b0) begin $display("FAIL ff_read_blocked got=%b exp=0", rr_gv); n_fail++; end n_tests++;
        rr_write = 4'b0100;
        @(negedge clk);
        #1;
        if (rr_gv !== 1'b1 || rr_grant !== 4'b0100 || rr_gid !== 2'd2) begin
            $display("FAIL ff_write_grant got=%b/%b exp=1/0100", rr_gv, rr_grant); n_fail++;
        end
        n_tests++;
        @(negedge clk);
        rr_write = '0; rr_read = 4'b0101; rr_rdv = 1'b1;
        #1;
        if (rr_rsel !== 4'b0001) begin $display("FAIL pp_rsel got=%b exp=0001", rr_rsel); n_fail++; end n_tests++;
        @(negedge clk);
        rr_read = 4'b0001;
        #1;
        if (rr_full !== 1'b1 || rr_empty !== 1'b0) begin $display("FAIL pp_full got=full%b/empty%b exp=1/0", rr_full, rr_empty); n_fail++; end n_tests++;
        if (rr_gv !== 1'b0) begin $display("FAIL pp_idle got=%b exp=0", rr_gv); n_fail++; end n_tests++;
        if (rr_rsel !== 4'b0001) begin $display("FAIL ff_rsel_first got=%b exp=0001", rr_rsel); n_fail++; end n_tests++;
        @(negedge clk);
        rr_rdv = 1'b0; rr_read = '0;
        #1;
        if (rr_gv !== 1'b1 || rr_gid !== 2'd0 || rr_full !== 1'b0) begin
            $display("FAIL ff_unblock got=%b/%0d/%b exp=1/0/0", rr_gv, rr_gid, rr_full); n_fail++;
        end
        n_tests++;
        begin
            logic [3:0] drain [3];
            drain = '{4'b0001, 4'b0001, 4'b0100};
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                rr_rdv = 1'b1;
                #1;
                if (rr_rsel !== drain[k]) begin $display("FAIL ff_drain[%0d] got=%b exp=%b", k, rr_rsel, drain[k]); n_fail++; end
                n_tests++;
            end
        end
        @(negedge clk);
        rr_rdv = 1'b0;
        #1;
        if (rr_empty !== 1'b1) begin $display("FAIL ff_empty got=%b exp=1", rr_empty); n_fail++; end n_tests++;
    endtask

    task automatic test_waitrequest();
        @(negedge clk);
        rr_read = 4'b0011; rr_swait = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            if (rr_gv !== 1'b1 || rr_grant !== 4'b0001) begin $display("FAIL ws_hold[%0d] got=%b/%b exp=1/0001", k, rr_gv, rr_grant); n_fail++; end
            n_tests++;
            if (rr_empty !== 1'b1 || rr_wreq !== 4'b1111) begin
                $display("FAIL ws_stall[%0d] got=empty%b/wreq%b exp=1/1111", k, rr_empty, rr_wreq); n_fail++;
            end
            n_tests++;
        end
        rr_swait = 1'b0;
        #1;
        if (rr_wreq !== 4'b1110) begin $display("FAIL ws_release got=%b exp=1110", rr_wreq); n_fail++; end n_tests++;
        @(negedge clk);
        rr_read = '0;
        #1;
        if (rr_gid !== 2'd1 || rr_empty !== 1'b0) begin $display("FAIL ws_accept got=%0d/%b exp=1/0", rr_gid, rr_empty); n_fail++; end n_tests++;
        @(negedge clk);
        rr_rdv = 1'b1;
        #1;
        if (rr_rsel !== 4'b0001) begin $display("FAIL ws_rsel got=%b exp=0001", rr_rsel); n_fail++; end n_tests++;
        @(negedge clk);
        rr_rdv = 1'b0;
        #1;
        if (rr_empty !== 1'b1) begin $display("FAIL ws_empty got=%b exp=1", rr_empty); n_fail++; end n_tests++;
    endtask

    task automatic test_fixed_priority();
        @(negedge clk);
        fp_write = 4'b1010;
        #1;
        if (fp_gv !== 1'b0) begin $display("FAIL fp_latency got=%b exp=0", fp_gv); n_fail++; end n_tests++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            if (fp_gv !== 1'b1 || fp_gid !== 2'd1) begin $display("FAIL fp_m1[%0d] got=%b/%0d exp=1/1", k, fp_gv, fp_gid); n_fail++; end
            n_tests++;
        end
        if (fp_wreq !== 4'b1101) begin $display("FAIL fp_wreq got=%b exp=1101", fp_wreq); n_fail++; end n_tests++;
        fp_write = 4'b1000;
        @(negedge clk);
        #1;
        if (fp_gv !== 1'b0) begin $display("FAIL fp_drop got=%b exp=0", fp_gv); n_fail++; end n_tests++;
        @(negedge clk);
        fp_write = '0;
        #1;
        if (fp_gv !== 1'b1 || fp_grant !== 4'b1000 || fp_gid !== 2'd3) begin
            $display("FAIL fp_m3 got=%b/%b exp=1/1000", fp_gv, fp_grant); n_fail++;
        end
        n_tests++;
        @(negedge clk);
        #1;
        if (fp_gv !== 1'b0) begin $display("FAIL fp_idle got=%b exp=0", fp_gv); n_fail++; end n_tests++;
    endtask

    task automatic test_err_rdv();
        @(negedge clk);
        #1;
        if (rr_err !== 1'b0) begin $display("FAIL err_pre got=%b exp=0", rr_err); n_fail++; end n_tests++;
        rr_rdv = 1'b1;
        #1;
        if (rr_rsel !== 4'b0000) begin $display("FAIL err_rsel got=%b exp=0000", rr_rsel); n_fail++; end n_tests++;
        @(negedge clk);
        rr_rdv = 1'b0;
        #1;
        if (rr_err !== 1'b1 || rr_empty !== 1'b1) begin $display("FAIL err_set got=%b/%b exp=1/1", rr_err, rr_empty); n_fail++; end n_tests++;
        repeat (3) @(negedge clk);
        #1;
        if (rr_err !== 1'b1) begin $display("FAIL err_sticky got=%b exp=1", rr_err); n_fail++; end n_tests++;
    endtask

    initial begin
        test_reset();
        test_rr_back_to_back();
        test_reset_mid_traffic();
        test_fifo_full();
        test_waitrequest();
        test_fixed_priority();
        test_err_rdv();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
